// File: rtl/csr_intr_ctrl.sv
// Machine-mode CSR block and external interrupt controller: synchronizes INTR_EXT, latches a
// pending edge, and holds mstatus/mtvec/mepc/mcause. Define CSR_INTR_COUNT_EN to add the 0xB03 taken-interrupt counter.
module csr_intr_ctrl (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        INTR_EXT,
  input  logic        INT_TAKEN,
  input  logic        CSR_WE,
  input  logic        MRET_EXEC,
  input  logic [11:0] ADDR,
  input  logic [31:0] WD,
  input  logic [31:0] PC,
  output logic [31:0] RD,
  output logic [31:0] MTVEC,
  output logic [31:0] MEPC,
  output logic        INTR,
  output logic        MIE
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_ICOUNT  = 12'hB03;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic [2:0]  r_fill;
  logic        r_pending;
  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic        w_edge;
  logic [31:0] w_icount;

  // r_fill arms the edge detector only once r_sync2 and r_sync3 both hold samples taken
  // after reset release, so a line already high at release never looks like a 0->1 edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_fill  <= 3'b000;
    end else begin
      r_sync1 <= INTR_EXT;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_fill  <= {r_fill[1:0], 1'b1};
    end
  end

  assign w_edge = r_sync2 & ~r_sync3 & r_fill[2];

  // A new edge beats a same-cycle INT_TAKEN so the later interrupt is not lost.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pending <= 1'b0;
    end else if (w_edge) begin
      r_pending <= 1'b1;
    end else if (INT_TAKEN) begin
      r_pending <= 1'b0;
    end
  end

  // Trap entry outranks CSR writes, which outrank mret.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_mtvec  <= '0;
      r_mepc   <= '0;
      r_mcause <= '0;
    end else if (INT_TAKEN) begin
      r_mepc   <= PC;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
      r_mcause <= CAUSE_EXT;
    end else if (CSR_WE) begin
      case (ADDR)
        ADDR_MSTATUS: begin
          r_mie  <= WD[3];
          r_mpie <= WD[7];
        end
        ADDR_MTVEC:  r_mtvec  <= {WD[31:2], 2'b00};
        ADDR_MEPC:   r_mepc   <= {WD[31:2], 2'b00};
        ADDR_MCAUSE: r_mcause <= WD;
        default: ;
      endcase
    end else if (MRET_EXEC) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end
  end

`ifdef CSR_INTR_COUNT_EN
  logic [31:0] r_icount;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_icount <= '0;
    end else if (INT_TAKEN) begin
      if (r_icount != 32'hFFFF_FFFF) begin
        r_icount <= r_icount + 32'd1;
      end
    end else if (CSR_WE && (ADDR == ADDR_ICOUNT)) begin
      r_icount <= WD;
    end
  end

  assign w_icount = r_icount;
`else
  assign w_icount = '0;
`endif

  // NOTE: RD gets a default before the case so no address path can infer a latch.
  always_comb begin
    RD = '0;
    case (ADDR)
      ADDR_MSTATUS: RD = {24'b0, r_mpie, 3'b000, r_mie, 3'b000};
      ADDR_MTVEC:   RD = r_mtvec;
      ADDR_MEPC:    RD = r_mepc;
      ADDR_MCAUSE:  RD = r_mcause;
      ADDR_ICOUNT:  RD = w_icount;
      default:      RD = '0;
    endcase
  end

  assign MTVEC = r_mtvec;
  assign MEPC  = r_mepc;
  assign MIE   = r_mie;
  assign INTR  = r_pending & r_mie;

endmodule

// File: tb/tb_csr_intr_ctrl.sv
// Scoreboard bench for csr_intr_ctrl: the stimulus pushes per-cycle expectations, and a
// negedge monitor pops and compares them against the live outputs.
module tb_csr_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        intr_ext;
  logic        int_taken;
  logic        csr_we;
  logic        mret_exec;
  logic [11:0] addr;
  logic [31:0] wd;
  logic [31:0] pc;
  logic [31:0] rd;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        intr;
  logic        mie;

  csr_intr_ctrl dut (
    .CLK(clk), .RST_N(rst_n), .INTR_EXT(intr_ext), .INT_TAKEN(int_taken),
    .CSR_WE(csr_we), .MRET_EXEC(mret_exec), .ADDR(addr), .WD(wd), .PC(pc),
    .RD(rd), .MTVEC(mtvec), .MEPC(mepc), .INTR(intr), .MIE(mie)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {S_RD, S_MTVEC, S_MEPC, S_INTR, S_MIE} sel_e;
  typedef struct {
    int          cyc;
    sel_e        sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t m_e;
  logic [31:0] m_act;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input bit on_time);
    checks++;
    if (!on_time || act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h%s", name, act, exp, on_time ? "" : " (late)");
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      case (m_e.sel)
        S_RD:    m_act = rd;
        S_MTVEC: m_act = mtvec;
        S_MEPC:  m_act = mepc;
        S_INTR:  m_act = {31'b0, intr};
        default: m_act = {31'b0, mie};
      endcase
      check(m_e.name, m_act, m_e.exp, m_e.cyc == cyc);
    end
  end

  task automatic expect_out(input string name, input sel_e sel, input logic [31:0] exp);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    csr_we    = 1'b0;
    mret_exec = 1'b0;
    int_taken = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1;
    addr   = a;
    wd     = d;
  endtask

  initial begin
    rst_n = 1'b0; intr_ext = 1'b0; int_taken = 1'b0; csr_we = 1'b0;
    mret_exec = 1'b0; addr = '0; wd = '0; pc = '0;

    tick(); addr = 12'h305;
    expect_out("rst_rd305", S_RD, 32'h0);
    expect_out("rst_mtvec", S_MTVEC, 32'h0);
    expect_out("rst_mepc", S_MEPC, 32'h0);
    expect_out("rst_intr", S_INTR, 32'h0);
    expect_out("rst_mie", S_MIE, 32'h0);
    tick(); addr = 12'h342; expect_out("rst_rd342", S_RD, 32'h0);
    tick(); rst_n = 1'b1;
    repeat (3) tick();

    tick(); csr_wr(12'h305, 32'h0000_0103); expect_out("mtvec_latency", S_MTVEC, 32'h0);
    tick(); addr = 12'h305;
    expect_out("mtvec_write", S_MTVEC, 32'h0000_0100);
    expect_out("rd_mtvec", S_RD, 32'h0000_0100);
    tick(); csr_wr(12'h300, 32'hFFFF_FFFF);
    tick(); addr = 12'h300;
    expect_out("mstatus_mask", S_RD, 32'h0000_0088);
    expect_out("mie_set", S_MIE, 32'h1);
    expect_out("intr_idle", S_INTR, 32'h0);
    csr_wr(12'h300, 32'h0000_0008);
    tick(); addr = 12'h300; expect_out("mstatus_w8", S_RD, 32'h0000_0008);

    tick(); intr_ext = 1'b1; expect_out("intr_p0", S_INTR, 32'h0);
    tick(); expect_out("intr_p1", S_INTR, 32'h0);
    tick(); expect_out("intr_p2", S_INTR, 32'h0);
    tick(); intr_ext = 1'b0; expect_out("intr_rise", S_INTR, 32'h1);
    tick(); expect_out("intr_hold", S_INTR, 32'h1);
    tick(); int_taken = 1'b1; pc = 32'h40;
    tick(); addr = 12'h342;
    expect_out("take_intr", S_INTR, 32'h0);
    expect_out("take_mie", S_MIE, 32'h0);
    expect_out("take_mepc", S_MEPC, 32'h40);
    expect_out("take_mcause", S_RD, 32'h8000_000B);
    tick(); addr = 12'h300; expect_out("take_mstatus", S_RD, 32'h0000_0080);

    tick(); intr_ext = 1'b1;
    tick();
    tick(); intr_ext = 1'b0;
    tick(); expect_out("masked_q3", S_INTR, 32'h0);
    tick(); expect_out("masked_q4", S_INTR, 32'h0); csr_wr(12'h300, 32'h0000_0008);
    tick();
    expect_out("unmask_intr", S_INTR, 32'h1);
    expect_out("unmask_mie", S_MIE, 32'h1);
    int_taken = 1'b1; pc = 32'h80;
    tick();
    expect_out("take2_intr", S_INTR, 32'h0);
    expect_out("take2_mie", S_MIE, 32'h0);
    expect_out("take2_mepc", S_MEPC, 32'h80);
    mret_exec = 1'b1;
    tick(); addr = 12'h300;
    expect_out("mret_mie", S_MIE, 32'h1);
    expect_out("mret_mstatus", S_RD, 32'h0000_0088);
    expect_out("mret_intr", S_INTR, 32'h0);
    tick(); csr_wr(12'h341, 32'h0000_1234); int_taken = 1'b1; pc = 32'hC0;
    tick(); addr = 12'h341;
    expect_out("take_vs_wr_rd", S_RD, 32'hC0);
    expect_out("take_vs_wr_mepc", S_MEPC, 32'hC0);
    expect_out("take_vs_wr_mie", S_MIE, 32'h0);
    tick(); csr_wr(12'h300, 32'h0); mret_exec = 1'b1;
    expect_out("pre_wr_mret", S_RD, 32'h0000_0080);
    tick(); addr = 12'h300;
    expect_out("wr_beats_mret", S_RD, 32'h0);
    expect_out("wr_beats_mret_mie", S_MIE, 32'h0);
    tick(); csr_wr(12'h341, 32'hFFFF_FFFF);
    tick(); expect_out("mepc_align", S_MEPC, 32'hFFFF_FFFC);
    tick(); csr_wr(12'h123, 32'hDEAD_BEEF);
    tick(); addr = 12'h123; expect_out("unmapped_rd", S_RD, 32'h0);
`ifndef CSR_INTR_COUNT_EN
    tick(); csr_wr(12'hB03, 32'hFFFF_FFFF);
    tick(); addr = 12'hB03; expect_out("no_counter", S_RD, 32'h0);
`endif

    tick(); intr_ext = 1'b1;
    tick();
    tick(); intr_ext = 1'b0; int_taken = 1'b1;
    tick(); csr_wr(12'h300, 32'h0000_0008);
    tick();
    expect_out("edge_wins_intr", S_INTR, 32'h1);
    expect_out("edge_wins_mie", S_MIE, 32'h1);
    int_taken = 1'b1;
    tick();
    expect_out("edge_wins_clr", S_INTR, 32'h0);
    expect_out("edge_wins_mie0", S_MIE, 32'h0);

    tick(); csr_wr(12'h300, 32'h0000_0008);
    tick(); intr_ext = 1'b1;
    tick();
    tick();
    tick(); expect_out("pend_before_rst", S_INTR, 32'h1);
    tick(); rst_n = 1'b0; addr = 12'h342;
    expect_out("async_rst_intr", S_INTR, 32'h0);
    expect_out("async_rst_mie", S_MIE, 32'h0);
    expect_out("async_rst_mtvec", S_MTVEC, 32'h0);
    expect_out("async_rst_mepc", S_MEPC, 32'h0);
    expect_out("async_rst_mcause", S_RD, 32'h0);
    tick(); addr = 12'h300; expect_out("rst_mstatus", S_RD, 32'h0);
    tick(); addr = 12'hB03; expect_out("rst_icount", S_RD, 32'h0);
    tick(); rst_n = 1'b1;
    tick(); csr_wr(12'h300, 32'h0000_0008);
    for (int i = 0; i < 5; i++) begin
      tick(); expect_out("level_no_edge", S_INTR, 32'h0);
    end
    tick(); intr_ext = 1'b0;
    tick();
    tick(); intr_ext = 1'b1;
    tick(); expect_out("post_rst_e1", S_INTR, 32'h0);
    tick(); expect_out("post_rst_e2", S_INTR, 32'h0);
    tick(); expect_out("post_rst_edge", S_INTR, 32'h1);

`ifdef CSR_INTR_COUNT_EN
    tick(); int_taken = 1'b1;
    tick();
    tick(); int_taken = 1'b1;
    tick(); int_taken = 1'b1;
    tick(); addr = 12'hB03; expect_out("icount_3", S_RD, 32'h3);
    csr_wr(12'hB03, 32'hFFFF_FFFF);
    tick(); addr = 12'hB03; int_taken = 1'b1; expect_out("icount_load", S_RD, 32'hFFFF_FFFF);
    tick(); addr = 12'hB03; expect_out("icount_sat", S_RD, 32'hFFFF_FFFF);
`endif

    tick();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
